// File: rtl/serial_link_noc_bridge_rx.sv
// Receive-side decoder of the serial-link NoC bridge: steers AXIS beats into request/response
// FIFOs, forwards piggy-backed credits, and counts freed slots owed to the far end.
// Optional macro SERIAL_LINK_RX_ERR_CHECK_EN enables the sticky err_o protocol checker.
module serial_link_noc_bridge_rx #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned NumCred   = 8,
    parameter int unsigned CredWidth = $clog2(NumCred + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 axis_valid_i,
    output logic                 axis_ready_o,
    input  logic [DataWidth:0]   axis_data_i,
    input  logic [CredWidth+1:0] axis_user_i,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output logic [DataWidth-1:0] req_data_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_data_o,
    output logic                 cred_rcvd_valid_o,
    output logic                 cred_rcvd_chan_o,
    output logic [CredWidth-1:0] cred_rcvd_o,
    output logic [CredWidth-1:0] free_req_o,
    output logic [CredWidth-1:0] free_rsp_o,
    input  logic                 free_consume_i,
    input  logic                 free_consume_chan_i,
    output logic                 err_o
);

    localparam int unsigned PtrWidth = (NumCred > 1) ? $clog2(NumCred) : 1;
    localparam logic [CredWidth-1:0] NumCredC = CredWidth'(NumCred);

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(NumCred - 1)) ? '0 : p + 1'b1;
    endfunction

    logic                 data_hdr;
    logic [DataWidth-1:0] payload;
    logic                 data_validity;
    logic                 credits_hdr;
    logic [CredWidth-1:0] credits;

    assign data_hdr = axis_data_i[DataWidth];
    assign payload  = axis_data_i[DataWidth-1:0];
    assign {data_validity, credits_hdr, credits} = axis_user_i;

    logic [DataWidth-1:0] mem_q   [2][NumCred];
    logic [DataWidth-1:0] mem_d   [2][NumCred];
    logic [PtrWidth-1:0]  wptr_q  [2];
    logic [PtrWidth-1:0]  wptr_d  [2];
    logic [PtrWidth-1:0]  rptr_q  [2];
    logic [PtrWidth-1:0]  rptr_d  [2];
    logic [CredWidth-1:0] cnt_q   [2];
    logic [CredWidth-1:0] cnt_d   [2];
    logic [CredWidth-1:0] free_q  [2];
    logic [CredWidth-1:0] free_d  [2];

    logic                 cred_valid_q, cred_valid_d;
    logic                 cred_chan_q, cred_chan_d;
    logic [CredWidth-1:0] cred_val_q, cred_val_d;

    logic [1:0] full, out_valid, out_ready, push, pop, consume;
    logic       accept;

    assign out_ready = {rsp_ready_i, req_ready_i};

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            full[c]      = (cnt_q[c] == NumCredC);
            out_valid[c] = (cnt_q[c] != '0);
        end
    end

    // Ready depends only on the incoming header bits and FIFO occupancy, never on the pop side.
    assign axis_ready_o = !rst_i & axis_valid_i & (!data_validity | !full[data_hdr]);
    assign accept       = axis_ready_o;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            push[c]    = accept & data_validity & (data_hdr == 1'(c));
            pop[c]     = out_valid[c] & out_ready[c];
            consume[c] = free_consume_i & (free_consume_chan_i == 1'(c));
        end
    end

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        free_d = free_q;
        for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
                mem_d[c][wptr_q[c]] = payload;
                wptr_d[c]           = ptr_inc(wptr_q[c]);
            end
            if (pop[c]) begin
                rptr_d[c] = ptr_inc(rptr_q[c]);
            end
            unique case ({push[c], pop[c]})
                2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
                2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
                default: cnt_d[c] = cnt_q[c];
            endcase
            // A consume returns the whole count; a coinciding pop is the first slot of the next batch.
            if (consume[c]) begin
                free_d[c] = pop[c] ? CredWidth'(1) : '0;
            end else if (pop[c]) begin
`ifdef SERIAL_LINK_RX_ERR_CHECK_EN
                free_d[c] = (free_q[c] == NumCredC) ? free_q[c] : free_q[c] + 1'b1;
`else
                free_d[c] = free_q[c] + 1'b1;
`endif
            end
        end
    end

    always_comb begin
        cred_valid_d = accept;
        cred_chan_d  = cred_chan_q;
        cred_val_d   = cred_val_q;
        if (accept) begin
            cred_chan_d = credits_hdr;
            cred_val_d  = credits;
        end
    end

`ifdef SERIAL_LINK_RX_ERR_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (axis_valid_i && data_validity && full[data_hdr]) begin
            err_d = 1'b1;
        end
        for (int c = 0; c < 2; c++) begin
            if (consume[c] && (free_q[c] == '0)) begin
                err_d = 1'b1;
            end
            if (!consume[c] && pop[c] && (free_q[c] == NumCredC)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < 2; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
                free_q[c] <= '0;
            end
            cred_valid_q <= 1'b0;
            cred_chan_q  <= 1'b0;
            cred_val_q   <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            free_q       <= free_d;
            cred_valid_q <= cred_valid_d;
            cred_chan_q  <= cred_chan_d;
            cred_val_q   <= cred_val_d;
        end
    end

    // Storage is not reset; empty FIFOs present zero on their data outputs instead.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign req_valid_o       = out_valid[0];
    assign rsp_valid_o       = out_valid[1];
    assign req_data_o        = out_valid[0] ? mem_q[0][rptr_q[0]] : '0;
    assign rsp_data_o        = out_valid[1] ? mem_q[1][rptr_q[1]] : '0;
    assign cred_rcvd_valid_o = cred_valid_q;
    assign cred_rcvd_chan_o  = cred_chan_q;
    assign cred_rcvd_o       = cred_val_q;
    assign free_req_o        = free_q[0];
    assign free_rsp_o        = free_q[1];

endmodule

// File: tb/tb_serial_link_noc_bridge_rx.sv
// Testbench for serial_link_noc_bridge_rx: directed table, corner sequences and random
// traffic against a queue-based reference model (honours SERIAL_LINK_RX_ERR_CHECK_EN).
module tb_serial_link_noc_bridge_rx;

    localparam int DW = 64;
    localparam int NC = 8;
    localparam int CW = $clog2(NC + 1);

    logic clk;
    logic rst, av, hdr, vld, chdr, rqr, rsr, cons, cch;
    logic [DW-1:0] pay;
    logic [CW-1:0] cr;

    logic          axis_ready_o, req_valid_o, rsp_valid_o;
    logic [DW-1:0] req_data_o, rsp_data_o;
    logic          cred_rcvd_valid_o, cred_rcvd_chan_o, err_o;
    logic [CW-1:0] cred_rcvd_o, free_req_o, free_rsp_o;

    serial_link_noc_bridge_rx #(.DataWidth(DW), .NumCred(NC)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .axis_valid_i        (av),
        .axis_ready_o        (axis_ready_o),
        .axis_data_i         ({hdr, pay}),
        .axis_user_i         ({vld, chdr, cr}),
        .req_valid_o         (req_valid_o),
        .req_ready_i         (rqr),
        .req_data_o          (req_data_o),
        .rsp_valid_o         (rsp_valid_o),
        .rsp_ready_i         (rsr),
        .rsp_data_o          (rsp_data_o),
        .cred_rcvd_valid_o   (cred_rcvd_valid_o),
        .cred_rcvd_chan_o    (cred_rcvd_chan_o),
        .cred_rcvd_o         (cred_rcvd_o),
        .free_req_o          (free_req_o),
        .free_rsp_o          (free_rsp_o),
        .free_consume_i      (cons),
        .free_consume_chan_i (cch),
        .err_o               (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as queues, owed credits as plain integers.
    logic [DW-1:0] mq0[$];
    logic [DW-1:0] mq1[$];
    int free_m[2];
    bit err_m, cv_m, cch_m;
    int cr_m;

    task automatic model_clear();
        mq0.delete();
        mq1.delete();
        free_m[0] = 0;
        free_m[1] = 0;
        err_m = 0;
        cv_m  = 0;
        cch_m = 0;
        cr_m  = 0;
    endtask

    task automatic set_in(input bit r, input bit a, input bit h, input logic [DW-1:0] p,
                          input bit v, input bit ch, input int c,
                          input bit qr, input bit sr, input bit cn, input bit cc);
        rst = r; av = a; hdr = h; pay = p; vld = v; chdr = ch; cr = CW'(c);
        rqr = qr; rsr = sr; cons = cn; cch = cc;
    endtask

    // One clock cycle: check all outputs against the model, then advance model and DUT.
    task automatic cycle();
        bit full_h, exp_ardy, pop0, pop1, pop_c, cons_c;
        logic [DW-1:0] d;
        #2;
        full_h   = hdr ? (mq1.size() >= NC) : (mq0.size() >= NC);
        exp_ardy = !rst && av && (!vld || !full_h);
        chk("axis_ready", axis_ready_o, exp_ardy);
        chk("req_valid", req_valid_o, mq0.size() > 0);
        chk("req_data", req_data_o, (mq0.size() > 0) ? mq0[0] : '0);
        chk("rsp_valid", rsp_valid_o, mq1.size() > 0);
        chk("rsp_data", rsp_data_o, (mq1.size() > 0) ? mq1[0] : '0);
        chk("free_req", free_req_o, free_m[0]);
        chk("free_rsp", free_rsp_o, free_m[1]);
        chk("cred_valid", cred_rcvd_valid_o, cv_m);
        if (cv_m) begin
            chk("cred_chan", cred_rcvd_chan_o, cch_m);
            chk("cred_val", cred_rcvd_o, cr_m);
        end
        chk("err", err_o, err_m);

        pop0 = (mq0.size() > 0) && rqr;
        pop1 = (mq1.size() > 0) && rsr;
        if (rst) begin
            model_clear();
        end else begin
`ifdef SERIAL_LINK_RX_ERR_CHECK_EN
            if (av && vld && full_h) err_m = 1;
`endif
            cv_m = exp_ardy;
            if (exp_ardy) begin
                cch_m = chdr;
                cr_m  = int'(cr);
            end
            if (exp_ardy && vld) begin
                if (hdr) mq1.push_back(pay);
                else     mq0.push_back(pay);
            end
            if (pop0) d = mq0.pop_front();
            if (pop1) d = mq1.pop_front();
            for (int c = 0; c < 2; c++) begin
                pop_c  = (c == 0) ? pop0 : pop1;
                cons_c = cons && (int'(cch) == c);
                if (cons_c) begin
`ifdef SERIAL_LINK_RX_ERR_CHECK_EN
                    if (free_m[c] == 0) err_m = 1;
`endif
                    free_m[c] = pop_c ? 1 : 0;
                end else if (pop_c) begin
`ifdef SERIAL_LINK_RX_ERR_CHECK_EN
                    if (free_m[c] == NC) err_m = 1;
                    else free_m[c] = free_m[c] + 1;
`else
                    free_m[c] = (free_m[c] + 1) % (1 << CW);
`endif
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit rst, av, hdr;
        logic [DW-1:0] pay;
        bit vld, chdr;
        int cr;
        bit rqr, rsr, cons, cch;
        bit e_ardy, e_rqv;
        logic [DW-1:0] e_rqd;
        bit e_rsv;
        logic [DW-1:0] e_rsd;
        int e_frq, e_frs;
        bit e_cv, e_cch;
        int e_cr;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Directed vectors: inputs for the cycle, outputs expected during that cycle.
        tbl[0]  = '{1,1,0,64'h0, 1,0,0, 0,0,0,0,  0,0,64'h0, 0,64'h0, 0,0, 0,0,0};
        tbl[1]  = '{1,1,0,64'h0, 1,0,0, 0,0,0,0,  0,0,64'h0, 0,64'h0, 0,0, 0,0,0};
        tbl[2]  = '{1,1,0,64'h0, 1,0,0, 0,0,0,0,  0,0,64'h0, 0,64'h0, 0,0, 0,0,0};
        tbl[3]  = '{0,1,0,64'hA5,1,1,3, 0,0,0,0,  1,0,64'h0, 0,64'h0, 0,0, 0,0,0};
        tbl[4]  = '{0,0,0,64'h0, 0,0,0, 0,0,0,0,  0,1,64'hA5,0,64'h0, 0,0, 1,1,3};
        tbl[5]  = '{0,0,0,64'h0, 0,0,0, 1,0,0,0,  0,1,64'hA5,0,64'h0, 0,0, 0,0,0};
        tbl[6]  = '{0,0,0,64'h0, 0,0,0, 0,0,0,0,  0,0,64'h0, 0,64'h0, 1,0, 0,0,0};
        tbl[7]  = '{0,1,0,64'h0, 0,0,0, 0,0,0,0,  1,0,64'h0, 0,64'h0, 1,0, 0,0,0};
        tbl[8]  = '{0,0,0,64'h0, 0,0,0, 0,0,0,0,  0,0,64'h0, 0,64'h0, 1,0, 1,0,0};
        tbl[9]  = '{0,0,0,64'h0, 0,0,0, 0,0,1,0,  0,0,64'h0, 0,64'h0, 1,0, 0,0,0};
        tbl[10] = '{0,0,0,64'h0, 0,0,0, 0,0,0,0,  0,0,64'h0, 0,64'h0, 0,0, 0,0,0};
        tbl[11] = '{0,1,1,64'h5A,1,0,7, 0,0,0,0,  1,0,64'h0, 0,64'h0, 0,0, 0,0,0};
        tbl[12] = '{0,0,0,64'h0, 0,0,0, 0,1,0,0,  0,0,64'h0, 1,64'h5A,0,0, 1,0,7};
        tbl[13] = '{0,0,0,64'h0, 0,0,0, 0,0,0,0,  0,0,64'h0, 0,64'h0, 0,1, 0,0,0};
        tbl[14] = '{0,0,0,64'h0, 0,0,0, 0,0,1,1,  0,0,64'h0, 0,64'h0, 0,1, 0,0,0};
        tbl[15] = '{0,0,0,64'h0, 0,0,0, 0,0,0,0,  0,0,64'h0, 0,64'h0, 0,0, 0,0,0};

        model_clear();
        set_in(1, 1, 0, '0, 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            set_in(tbl[i].rst, tbl[i].av, tbl[i].hdr, tbl[i].pay, tbl[i].vld, tbl[i].chdr,
                   tbl[i].cr, tbl[i].rqr, tbl[i].rsr, tbl[i].cons, tbl[i].cch);
            #1;
            chk($sformatf("tbl%0d_ardy", i), axis_ready_o, tbl[i].e_ardy);
            chk($sformatf("tbl%0d_rqv", i), req_valid_o, tbl[i].e_rqv);
            chk($sformatf("tbl%0d_rqd", i), req_data_o, tbl[i].e_rqd);
            chk($sformatf("tbl%0d_rsv", i), rsp_valid_o, tbl[i].e_rsv);
            chk($sformatf("tbl%0d_rsd", i), rsp_data_o, tbl[i].e_rsd);
            chk($sformatf("tbl%0d_frq", i), free_req_o, tbl[i].e_frq);
            chk($sformatf("tbl%0d_frs", i), free_rsp_o, tbl[i].e_frs);
            chk($sformatf("tbl%0d_cv", i), cred_rcvd_valid_o, tbl[i].e_cv);
            if (tbl[i].e_cv) begin
                chk($sformatf("tbl%0d_cch", i), cred_rcvd_chan_o, tbl[i].e_cch);
                chk($sformatf("tbl%0d_cr", i), cred_rcvd_o, tbl[i].e_cr);
            end
            cycle();
        end

        // Fill the request FIFO, then offer a ninth request that must stall.
        for (int i = 0; i < NC; i++) begin
            set_in(0, 1, 0, 64'(100 + i), 1, 0, 1, 0, 0, 0, 0);
            cycle();
        end
        set_in(0, 1, 0, 64'h999, 1, 0, 1, 0, 0, 0, 0);
        #2;
        chk("req_full_stall", axis_ready_o, 1'b0);
        cycle();
`ifdef SERIAL_LINK_RX_ERR_CHECK_EN
        chk("err_full", err_o, 1'b1);
`else
        chk("err_full", err_o, 1'b0);
`endif
        for (int i = 0; i < NC; i++) begin
            set_in(0, 1, 1, 64'(64'hBEEF0 + i), 1, 1, 2, 0, 0, 0, 0);
            #2;
            chk("rsp_accept", axis_ready_o, 1'b1);
            cycle();
        end

        // Both FIFOs full: credit-only beats still go through.
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, i[0], 64'hDEAD, 0, i[1], i + 1, 0, 0, 0, 0);
            #2;
            chk("cred_only_accept", axis_ready_o, 1'b1);
            cycle();
        end
        set_in(0, 0, 0, '0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("cred_only_rsp_full", rsp_valid_o, 1'b1);
        chk("cred_only_req_head", req_data_o, 64'd100);

        // Drain eight requests back to back, then return them while a response pops.
        for (int i = 0; i < NC; i++) begin
            set_in(0, 0, 0, '0, 0, 0, 0, 1, 0, 0, 0);
            cycle();
        end
        chk("drain_free_req", free_req_o, NC);
        chk("drain_req_empty", req_valid_o, 1'b0);
        set_in(0, 0, 0, '0, 0, 0, 0, 0, 1, 1, 0);
        cycle();
        chk("consume_req_zero", free_req_o, 0);
        chk("consume_req_rsp_inc", free_rsp_o, 1);
        set_in(0, 0, 0, '0, 0, 0, 0, 0, 1, 1, 1);
        cycle();
        chk("consume_rsp_with_pop", free_rsp_o, 1);
        set_in(0, 0, 0, '0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
`ifdef SERIAL_LINK_RX_ERR_CHECK_EN
        chk("err_consume_zero", err_o, 1'b1);
`else
        chk("err_consume_zero", err_o, 1'b0);
`endif

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 249) == 0, ($urandom % 4) != 0, $urandom % 2,
                   {$urandom, $urandom}, ($urandom % 4) != 0, $urandom % 2,
                   $urandom_range(0, NC), $urandom % 2, $urandom % 2,
                   ($urandom % 8) == 0, $urandom % 2);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
